imem_boot_ctrl: RTL and testbench
=================================

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, meaning imem word-address width (2^AW words).
REQ-002 SHALL have parameter HALT_PC, default 32'h000000ff, meaning the PC value that ends a run.
REQ-003 SHALL have parameter MAX_CYCLES, default 32'd100000, meaning the run-cycle limit before timeout.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1, meaning the reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, meaning a pulse that begins a load-and-run sequence.
REQ-007 SHALL have the loader handshake ports ld_valid (input, 1), ld_ready (output, 1), ld_data (input, 32) and ld_last (input, 1, marks the final word).
REQ-008 SHALL have the imem write ports imem_we (output, 1), imem_addr (output, AW, word address) and imem_wdata (output, 32).
REQ-009 SHALL have port core_rstn, output, 1, meaning the active-low reset to the single-cycle core.
REQ-010 SHALL have port pcW, input, 32, meaning the core's writeback PC.
REQ-011 SHALL have status outputs busy (1), done (1), timeout (1), cycle_cnt (32, run cycles) and word_cnt (AW+1, words loaded).

Function
REQ-012 SHALL implement the states IDLE, LOAD, RUN and HALT.
REQ-013 SHALL, in IDLE, hold ld_ready=0 and core_rstn=0, and on start=1 move to LOAD, clearing word_cnt, cycle_cnt, done and timeout.
REQ-014 SHALL, in LOAD, drive ld_ready=1; a beat is accepted when ld_valid and ld_ready are both 1.
REQ-015 SHALL register each accepted beat, so that imem_we=1, imem_addr=word_cnt (pre-increment) and imem_wdata=ld_data appear in the cycle after acceptance for exactly one cycle; word_cnt increments by 1 per beat.
REQ-016 SHALL treat the beat as final, leaving LOAD for RUN at the next edge, when it carries ld_last=1 or is written to address 2^AW-1; ld_ready is 0 from that edge on.
REQ-017 SHALL hold imem_we=0 whenever no beat was accepted in the previous cycle; ld_valid while ld_ready=0 has no effect.
REQ-018 SHALL drive core_rstn from a register equal to (state==RUN), so the core leaves reset one cycle after the final imem write.
REQ-019 SHALL, in RUN, increment cycle_cnt every cycle starting from 0 at the RUN entry edge.
REQ-020 SHALL, in RUN, go to HALT and set done=1 when pcW==HALT_PC; pcW is ignored outside RUN.
REQ-021 SHALL, in RUN, go to HALT and set timeout=1 when cycle_cnt==MAX_CYCLES-1 and pcW!=HALT_PC.
REQ-022 SHALL give the halt condition priority when halt and timeout occur in the same cycle: done=1, timeout=0.
REQ-023 SHALL, in HALT, drive core_rstn=0 from the next cycle, keep done, timeout, cycle_cnt and word_cnt frozen, and on start=1 re-enter LOAD with the clears of REQ-013.
REQ-024 SHALL ignore start while in LOAD or RUN.
REQ-025 SHALL drive busy=1 exactly in LOAD and RUN.

Reset
REQ-026 SHALL, when rstn=0 at any time including mid-load or mid-run, immediately force state=IDLE, ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rstn=0, busy=0, done=0, timeout=0, cycle_cnt=0 and word_cnt=0.
REQ-027 SHALL, after rstn rises, remain in IDLE until start=1.

Verification
REQ-028 SHALL cover this case: start, then 3 beats 0x00000293/0x00000313/0x00000067 with ld_last on the third -> imem writes at addr 0,1,2, one cycle after each beat; word_cnt=3; core_rstn=1 two cycles after the third acceptance.
REQ-029 SHALL cover this case: in RUN, pcW=0x000000ff at run cycle 10 -> done=1, timeout=0, cycle_cnt frozen at 10, core_rstn=0 in the following cycle.
REQ-030 SHALL cover this case: MAX_CYCLES=16 and pcW never equals HALT_PC -> timeout=1 and done=0 after 16 run cycles, cycle_cnt=15.
REQ-031 SHALL cover this case: AW=2, 6 beats offered with no ld_last -> only 4 writes (addr 0..3) occur, ld_ready drops after the 4th, word_cnt=4, RUN is entered.
REQ-032 SHALL cover this case: rstn pulsed low mid-LOAD after 2 beats -> all outputs reach reset values without waiting for a clock edge; a new start reloads from addr 0.
REQ-033 SHALL cover this case: in RUN, pcW==HALT_PC in the same cycle that cycle_cnt==MAX_CYCLES-1 -> done=1, timeout=0.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Boot controller: streams loader beats into instruction memory, then runs the core
// until it reaches HALT_PC or exhausts the cycle budget.
module imem_boot_ctrl #(
  parameter int unsigned AW         = 8,
  parameter logic [31:0] HALT_PC    = 32'h000000ff,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rstn,
  input  logic [31:0]   pcW,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [31:0]   cycle_cnt,
  output logic [AW:0]   word_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  localparam logic [AW:0] LAST_WC  = {1'b0, {AW{1'b1}}};
  localparam logic [31:0] LAST_CYC = MAX_CYCLES - 32'd1;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            core_rstn_q;
  logic            done_q, done_d;
  logic            to_q, to_d;
  logic [31:0]     cc_q, cc_d;
  logic [AW:0]     wc_q, wc_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      core_rstn_q <= 1'b0;
      done_q      <= 1'b0;
      to_q        <= 1'b0;
      cc_q        <= '0;
      wc_q        <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      core_rstn_q <= (state_q == RUN);
      done_q      <= done_d;
      to_q        <= to_d;
      cc_q        <= cc_d;
      wc_q        <= wc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    to_d    = to_q;
    cc_d    = cc_q;
    wc_d    = wc_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = LOAD;
          wc_d    = '0;
          cc_d    = '0;
          done_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          we_d    = 1'b1;
          addr_d  = wc_q[AW-1:0];
          wdata_d = ld_data;
          wc_d    = wc_q + 1'b1;
          // A full memory ends the load even without ld_last.
          if (ld_last || (wc_q == LAST_WC)) begin
            state_d = RUN;
            cc_d    = '0;
          end
        end
      end
      RUN: begin
        // Halt wins over timeout; the counter freezes on the exit cycle.
        if (pcW == HALT_PC) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else if (cc_q == LAST_CYC) begin
          state_d = HALT;
          to_d    = 1'b1;
        end else begin
          cc_d = cc_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_ready   = (state_q == LOAD);
  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rstn  = core_rstn_q;
  assign done       = done_q;
  assign timeout    = to_q;
  assign cycle_cnt  = cc_q;
  assign word_cnt   = wc_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a scoreboard of expected imem writes.
module tb_imem_boot_ctrl;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rstn;
  logic [31:0]   pcW;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [31:0]   cycle_cnt;
  logic [AW:0]   word_cnt;

  imem_boot_ctrl #(.AW(AW), .HALT_PC(32'h000000ff), .MAX_CYCLES(32'd16)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rstn(core_rstn), .pcW(pcW), .busy(busy), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;
  int  exp_wc   = 0;
  bit  exp_loading = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample #1 later; each scoreboard entry must appear on the very next edge.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("imem_we", 64'(imem_we), 64'd1);
      check("imem_addr", 64'(imem_addr), 64'(e.addr));
      check("imem_wdata", 64'(imem_wdata), 64'(e.data));
    end else begin
      check("imem_we_idle", 64'(imem_we), 64'd0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_wc = 0;
    exp_loading = 1'b1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    wr_t e;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    check("ld_ready", 64'(ld_ready), 64'(exp_loading));
    if (exp_loading) begin
      e.addr = exp_wc[AW-1:0];
      e.data = d;
      sb.push_back(e);
      if (last || exp_wc == (1 << AW) - 1) exp_loading = 1'b0;
      exp_wc++;
    end
    tick();
  endtask

  task automatic wait_cycle(input int k);
    int n = 0;
    while (cycle_cnt != 32'(k) && n < 40) begin
      tick();
      n++;
    end
    check("wait_cycle", 64'(cycle_cnt), 64'(k));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_ready"}, 64'(ld_ready), 64'd0);
    check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_core_rstn"}, 64'(core_rstn), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    check({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rstn = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; pcW = '0;
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    tick();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_core_rstn", 64'(core_rstn), 64'd0);

    // Three-beat load; pcW at HALT_PC during LOAD must be ignored.
    pcW = 32'h000000ff;
    do_start();
    check("load_busy", 64'(busy), 64'd1);
    drive_beat(32'h00000293, 1'b0);
    drive_beat(32'h00000313, 1'b0);
    drive_beat(32'h00000067, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0; pcW = '0;
    check("t1_ld_ready_off", 64'(ld_ready), 64'd0);
    check("t1_core_rstn_lo", 64'(core_rstn), 64'd0);
    check("t1_word_cnt", 64'(word_cnt), 64'd3);
    check("t1_cycle0", 64'(cycle_cnt), 64'd0);
    tick();
    check("t1_core_rstn_hi", 64'(core_rstn), 64'd1);
    check("t1_cycle1", 64'(cycle_cnt), 64'd1);

    // Start during RUN is ignored.
    wait_cycle(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_start_ign_cc", 64'(cycle_cnt), 64'd6);
    check("run_start_ign_busy", 64'(busy), 64'd1);

    wait_cycle(10);
    pcW = 32'h000000ff;
    tick();
    pcW = '0;
    check("halt_done", 64'(done), 64'd1);
    check("halt_timeout", 64'(timeout), 64'd0);
    check("halt_cc", 64'(cycle_cnt), 64'd10);
    check("halt_busy", 64'(busy), 64'd0);
    check("halt_core_rstn_still", 64'(core_rstn), 64'd1);
    tick();
    check("halt_core_rstn_lo", 64'(core_rstn), 64'd0);
    check("halt_cc_frozen", 64'(cycle_cnt), 64'd10);
    check("halt_done_held", 64'(done), 64'd1);
    check("halt_wc_frozen", 64'(word_cnt), 64'd3);

    // Timeout after 16 run cycles.
    do_start();
    check("restart_done_clr", 64'(done), 64'd0);
    check("restart_cc_clr", 64'(cycle_cnt), 64'd0);
    check("restart_wc_clr", 64'(word_cnt), 64'd0);
    check("restart_ready", 64'(ld_ready), 64'd1);
    drive_beat(32'h11111111, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("to_run_cycles", 64'(n), 64'd16);
    check("to_timeout", 64'(timeout), 64'd1);
    check("to_done", 64'(done), 64'd0);
    check("to_cc", 64'(cycle_cnt), 64'd15);

    // Halt coinciding with the last allowed cycle: halt wins.
    do_start();
    check("restart_to_clr", 64'(timeout), 64'd0);
    drive_beat(32'h22222222, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    wait_cycle(15);
    pcW = 32'h000000ff;
    tick();
    pcW = '0;
    check("tie_done", 64'(done), 64'd1);
    check("tie_timeout", 64'(timeout), 64'd0);
    check("tie_cc", 64'(cycle_cnt), 64'd15);

    // Six beats without ld_last into a 4-word memory; start mid-load is ignored.
    do_start();
    for (int i = 0; i < 6; i++) begin
      start = (i == 2);
      drive_beat(32'hA0000000 + 32'(i), 1'b0);
    end
    start = 1'b0; ld_valid = 1'b0;
    check("full_wc", 64'(word_cnt), 64'd4);
    check("full_busy", 64'(busy), 64'd1);
    check("full_ready", 64'(ld_ready), 64'd0);
    check("full_core_rstn", 64'(core_rstn), 64'd1);
    pcW = 32'h000000ff;
    tick();
    pcW = '0;
    check("full_done", 64'(done), 64'd1);

    // Asynchronous reset mid-load, then reload from address 0.
    do_start();
    drive_beat(32'hB0000000, 1'b0);
    drive_beat(32'hB0000001, 1'b0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("arst");
    #1;
    rstn = 1'b1;
    ld_valid = 1'b0;
    exp_loading = 1'b0;
    tick();
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_ready", 64'(ld_ready), 64'd0);
    do_start();
    drive_beat(32'hC0000000, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    check("reload_wc", 64'(word_cnt), 64'd1);
    tick();
    pcW = 32'h000000ff;
    tick();
    pcW = '0;
    check("reload_done", 64'(done), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
